// File: rtl/seg_click_toggler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_click_toggler: mouse-click to 7-segment toggle front end for the     |
// | OLED segment renderer. Optional undo buffer enabled by SEG_UNDO_EN.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg_click_toggler #(
    parameter int HOLDOFF_CYCLES = 100000,
    parameter int HIT_MARGIN     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] mouse_x,
    input  logic [5:0] mouse_y,
    input  logic       left_btn,
    input  logic       right_btn,
    output logic [6:0] seg_state,
    output logic       hit_valid,
    output logic       hit_miss,
    output logic [2:0] hit_index,
    output logic       busy
);

    localparam int               CNT_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [7:0]       MARGIN   = 8'(HIT_MARGIN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LATCH    = 3'd1;
    localparam logic [2:0] S_APPLY    = 3'd2;
    localparam logic [2:0] S_LOCKOUT  = 3'd3;
    localparam logic [2:0] S_WAIT_REL = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       cap_x_q, cap_x_d;
    logic [5:0]       cap_y_q, cap_y_d;
    logic             hit_flag_q, hit_flag_d;
    logic [2:0]       hit_idx_q, hit_idx_d;
    logic [6:0]       seg_state_q, seg_state_d;
    logic             hit_valid_q, hit_valid_d;
    logic             hit_miss_q, hit_miss_d;
    logic [2:0]       hit_index_q, hit_index_d;

    logic             lsync1_q, lsync1_d;
    logic             lsync2_q, lsync2_d;
    logic             ldly_q, ldly_d;
    logic             larm_q, larm_d;
    logic [1:0]       fill_q, fill_d;
    logic             l_press;

`ifdef SEG_UNDO_EN
    logic             rsync1_q, rsync1_d;
    logic             rsync2_q, rsync2_d;
    logic             rdly_q, rdly_d;
    logic             rarm_q, rarm_d;
    logic [6:0]       undo_buf_q, undo_buf_d;
    logic             undo_ok_q, undo_ok_d;
    logic             r_press;
`else
    logic             unused_right_btn;
    assign unused_right_btn = right_btn;
`endif

    logic [7:0] px, py;
    logic [6:0] box_hit;
    logic       hit_any;
    logic [2:0] hit_sel;

    function automatic logic in_box(input logic [7:0] x, input logic [7:0] y,
                                    input logic [7:0] xl, input logic [7:0] xh,
                                    input logic [7:0] yl, input logic [7:0] yh);
        in_box = (x >= xl - MARGIN) && (x <= xh + MARGIN) &&
                 (y >= yl - MARGIN) && (y <= yh + MARGIN);
    endfunction

    assign px = {1'b0, cap_x_q};
    assign py = {2'b00, cap_y_q};

    always_comb begin
        box_hit[0] = in_box(px, py, 8'd9,  8'd29, 8'd4,  8'd6);
        box_hit[1] = in_box(px, py, 8'd27, 8'd29, 8'd4,  8'd27);
        box_hit[2] = in_box(px, py, 8'd27, 8'd29, 8'd29, 8'd47);
        box_hit[3] = in_box(px, py, 8'd9,  8'd29, 8'd45, 8'd47);
        box_hit[4] = in_box(px, py, 8'd9,  8'd11, 8'd29, 8'd47);
        box_hit[5] = in_box(px, py, 8'd9,  8'd11, 8'd4,  8'd27);
        box_hit[6] = in_box(px, py, 8'd9,  8'd29, 8'd26, 8'd28);
    end

    // Scan downwards so the lowest overlapping index is the one left standing.
    always_comb begin
        hit_any = |box_hit;
        hit_sel = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (box_hit[i]) hit_sel = 3'(i);
        end
    end

    // fill_q marks when the sync chain holds real samples; arming needs a real
    // low first, so a button held across reset release never counts as a press.
    always_comb begin
        fill_d   = {fill_q[0], 1'b1};
        lsync1_d = left_btn;
        lsync2_d = lsync1_q;
        ldly_d   = lsync2_q;
        larm_d   = larm_q | (fill_q[1] & ~lsync2_q);
        l_press  = lsync2_q & ~ldly_q & larm_q;
`ifdef SEG_UNDO_EN
        rsync1_d = right_btn;
        rsync2_d = rsync1_q;
        rdly_d   = rsync2_q;
        rarm_d   = rarm_q | (fill_q[1] & ~rsync2_q);
        r_press  = rsync2_q & ~rdly_q & rarm_q;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_x_d     = cap_x_q;
        cap_y_d     = cap_y_q;
        hit_flag_d  = hit_flag_q;
        hit_idx_d   = hit_idx_q;
        seg_state_d = seg_state_q;
        hit_index_d = hit_index_q;
        hit_valid_d = 1'b0;
        hit_miss_d  = 1'b0;
`ifdef SEG_UNDO_EN
        undo_buf_d  = undo_buf_q;
        undo_ok_d   = undo_ok_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (l_press) begin
                    cap_x_d = mouse_x;
                    cap_y_d = mouse_y;
                    state_d = S_LATCH;
                end
`ifdef SEG_UNDO_EN
                else if (r_press && undo_ok_q) begin
                    seg_state_d = undo_buf_q;
                    undo_ok_d   = 1'b0;
                    hit_valid_d = 1'b1;
                    cnt_d       = CNT_LOAD;
                    state_d     = S_LOCKOUT;
                end
`endif
            end
            S_LATCH: begin
                hit_flag_d = hit_any;
                hit_idx_d  = hit_sel;
                state_d    = S_APPLY;
            end
            S_APPLY: begin
                if (hit_flag_q) begin
                    seg_state_d = seg_state_q ^ (7'(1) << hit_idx_q);
                    hit_index_d = hit_idx_q;
                    hit_valid_d = 1'b1;
`ifdef SEG_UNDO_EN
                    undo_buf_d  = seg_state_q;
                    undo_ok_d   = 1'b1;
`endif
                end else begin
                    hit_miss_d = 1'b1;
                end
                cnt_d   = CNT_LOAD;
                state_d = S_LOCKOUT;
            end
            S_LOCKOUT: begin
                if (cnt_q == '0) state_d = S_WAIT_REL;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WAIT_REL: begin
                if (!lsync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cap_x_q     <= '0;
            cap_y_q     <= '0;
            hit_flag_q  <= 1'b0;
            hit_idx_q   <= '0;
            seg_state_q <= '0;
            hit_valid_q <= 1'b0;
            hit_miss_q  <= 1'b0;
            hit_index_q <= '0;
            lsync1_q    <= 1'b0;
            lsync2_q    <= 1'b0;
            ldly_q      <= 1'b0;
            larm_q      <= 1'b0;
            fill_q      <= '0;
`ifdef SEG_UNDO_EN
            rsync1_q    <= 1'b0;
            rsync2_q    <= 1'b0;
            rdly_q      <= 1'b0;
            rarm_q      <= 1'b0;
            undo_buf_q  <= '0;
            undo_ok_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_x_q     <= cap_x_d;
            cap_y_q     <= cap_y_d;
            hit_flag_q  <= hit_flag_d;
            hit_idx_q   <= hit_idx_d;
            seg_state_q <= seg_state_d;
            hit_valid_q <= hit_valid_d;
            hit_miss_q  <= hit_miss_d;
            hit_index_q <= hit_index_d;
            lsync1_q    <= lsync1_d;
            lsync2_q    <= lsync2_d;
            ldly_q      <= ldly_d;
            larm_q      <= larm_d;
            fill_q      <= fill_d;
`ifdef SEG_UNDO_EN
            rsync1_q    <= rsync1_d;
            rsync2_q    <= rsync2_d;
            rdly_q      <= rdly_d;
            rarm_q      <= rarm_d;
            undo_buf_q  <= undo_buf_d;
            undo_ok_q   <= undo_ok_d;
`endif
        end
    end

    assign seg_state = seg_state_q;
    assign hit_valid = hit_valid_q;
    assign hit_miss  = hit_miss_q;
    assign hit_index = hit_index_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seg_click_toggler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg_click_toggler: table, corner-case and random click checks for     |
// | seg_click_toggler (HOLDOFF_CYCLES=4, HIT_MARGIN=1).                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_seg_click_toggler;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] mouse_x;
    logic [5:0] mouse_y;
    logic       left_btn;
    logic       right_btn;
    logic [6:0] seg_state;
    logic       hit_valid;
    logic       hit_miss;
    logic [2:0] hit_index;
    logic       busy;

    seg_click_toggler #(
        .HOLDOFF_CYCLES (4),
        .HIT_MARGIN     (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mouse_x   (mouse_x),
        .mouse_y   (mouse_y),
        .left_btn  (left_btn),
        .right_btn (right_btn),
        .seg_state (seg_state),
        .hit_valid (hit_valid),
        .hit_miss  (hit_miss),
        .hit_index (hit_index),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit hit;
        int idx;
    } vec_t;

    vec_t tbl[20];
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_seg     = 0;
    int   exp_idx     = 0;

    // Segment boxes as drawn on the OLED, before margin widening.
    int box_xl[7] = '{9, 27, 27, 9, 9, 9, 9};
    int box_xh[7] = '{29, 29, 29, 29, 11, 11, 29};
    int box_yl[7] = '{4, 4, 29, 45, 29, 4, 26};
    int box_yh[7] = '{6, 27, 47, 47, 47, 27, 28};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model_hit(input int x, input int y, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            if (!hit && x >= box_xl[i] - 1 && x <= box_xh[i] + 1 &&
                y >= box_yl[i] - 1 && y <= box_yh[i] + 1) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk("idle_timeout_busy", int'(busy), 0);
        tick();
        tick();
    endtask

    task automatic do_click(input int x, input int y, input bit hit, input int idx);
        mouse_x  = 7'(x);
        mouse_y  = 6'(y);
        left_btn = 1'b1;
        repeat (3) tick();
        mouse_x  = 7'($urandom_range(0, 95));
        mouse_y  = 6'($urandom_range(0, 63));
        tick();
        chk("busy_mid_click", int'(busy), 1);
        chk("no_early_pulse", int'(hit_valid | hit_miss), 0);
        tick();
        if (hit) begin
            exp_seg = exp_seg ^ (1 << idx);
            exp_idx = idx;
        end
        chk("hit_valid", int'(hit_valid), int'(hit));
        chk("hit_miss", int'(hit_miss), int'(!hit));
        chk("seg_state", int'(seg_state), exp_seg);
        chk("hit_index", int'(hit_index), exp_idx);
        tick();
        chk("pulse_one_cycle", int'(hit_valid | hit_miss), 0);
        left_btn = 1'b0;
        wait_idle();
    endtask

    initial begin
        bit   mh;
        int   mi;
        int   pulses;
        logic [19:0] pat;

        tbl[0]  = '{20, 5, 1, 0};
        tbl[1]  = '{28, 15, 1, 1};
        tbl[2]  = '{28, 15, 1, 1};
        tbl[3]  = '{28, 5, 1, 0};
        tbl[4]  = '{60, 40, 0, 0};
        tbl[5]  = '{28, 35, 1, 2};
        tbl[6]  = '{20, 46, 1, 3};
        tbl[7]  = '{10, 35, 1, 4};
        tbl[8]  = '{10, 15, 1, 5};
        tbl[9]  = '{20, 27, 1, 6};
        tbl[10] = '{8, 5, 1, 0};
        tbl[11] = '{7, 5, 0, 0};
        tbl[12] = '{31, 5, 0, 0};
        tbl[13] = '{20, 3, 1, 0};
        tbl[14] = '{20, 2, 0, 0};
        tbl[15] = '{28, 28, 1, 1};
        tbl[16] = '{28, 29, 1, 2};
        tbl[17] = '{10, 27, 1, 5};
        tbl[18] = '{95, 63, 0, 0};
        tbl[19] = '{20, 8, 0, 0};

        reset     = 1'b1;
        left_btn  = 1'b0;
        right_btn = 1'b0;
        mouse_x   = '0;
        mouse_y   = '0;
        repeat (3) tick();
        chk("rst_seg", int'(seg_state), 0);
        chk("rst_valid", int'(hit_valid), 0);
        chk("rst_miss", int'(hit_miss), 0);
        chk("rst_index", int'(hit_index), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 20; i++) begin
            do_click(tbl[i].x, tbl[i].y, tbl[i].hit, tbl[i].idx);
        end

        // Held press with three bounces: only the first edge counts.
        mouse_x = 7'd10;
        mouse_y = 6'd35;
        pat     = 20'hFFFD5;
        pulses  = 0;
        for (int i = 0; i < 20; i++) begin
            left_btn = pat[i];
            tick();
            if (hit_valid) pulses++;
        end
        exp_seg = exp_seg ^ (1 << 4);
        exp_idx = 4;
        chk("bounce_pulses", pulses, 1);
        chk("bounce_seg", int'(seg_state), exp_seg);
        chk("bounce_held_busy", int'(busy), 1);
        left_btn = 1'b0;
        wait_idle();
        chk("bounce_no_late_toggle", int'(seg_state), exp_seg);
        do_click(10, 35, 1'b1, 4);

        // Button held across reset release must not toggle.
        left_btn = 1'b1;
        reset    = 1'b1;
        repeat (2) tick();
        reset   = 1'b0;
        exp_seg = 0;
        exp_idx = 0;
        pulses  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (hit_valid || hit_miss || busy) pulses++;
        end
        chk("held_reset_activity", pulses, 0);
        chk("held_reset_seg", int'(seg_state), 0);
        left_btn = 1'b0;
        repeat (3) tick();
        do_click(20, 5, 1'b1, 0);

        // Reset while in LATCH abandons the click.
        mouse_x  = 7'd20;
        mouse_y  = 6'd46;
        left_btn = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        exp_seg = 0;
        exp_idx = 0;
        chk("latch_rst_seg", int'(seg_state), 0);
        chk("latch_rst_busy", int'(busy), 0);
        chk("latch_rst_pulse", int'(hit_valid | hit_miss), 0);
        reset    = 1'b0;
        left_btn = 1'b0;
        repeat (6) tick();
        chk("latch_rst_after_seg", int'(seg_state), 0);
        chk("latch_rst_after_busy", int'(busy), 0);

`ifdef SEG_UNDO_EN
        do_click(20, 27, 1'b1, 6);
        right_btn = 1'b1;
        repeat (3) tick();
        exp_seg = 0;
        chk("undo_seg", int'(seg_state), 0);
        chk("undo_valid", int'(hit_valid), 1);
        chk("undo_index", int'(hit_index), 6);
        tick();
        chk("undo_pulse_one_cycle", int'(hit_valid), 0);
        right_btn = 1'b0;
        wait_idle();
        right_btn = 1'b1;
        pulses    = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (hit_valid || busy) pulses++;
        end
        chk("undo_second_activity", pulses, 0);
        chk("undo_second_seg", int'(seg_state), 0);
        right_btn = 1'b0;
        repeat (3) tick();
`endif

        for (int n = 0; n < 30; n++) begin
            int rx;
            int ry;
            if (n % 2 == 0) begin
                rx = $urandom_range(0, 95);
                ry = $urandom_range(0, 63);
            end else begin
                rx = $urandom_range(6, 32);
                ry = $urandom_range(0, 50);
            end
            model_hit(rx, ry, mh, mi);
            do_click(rx, ry, mh, mi);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
